hsv_core_commit: RTL and testbench
==================================

// Module: hsv_core_commit
// PURPOSE
// - In-order commit stage directly downstream of the execution units (ALU, branch, memory).
// - Takes per-unit result handshakes, retires results strictly in program order by tag,
//   and drives register-file writeback.
// - Reports the first excepting instruction as a trap, then holds until the core flushes.
// PARAMETERS
// - N_SRC   3   number of execution-unit source channels; index 0 = ALU
// - TAG_W   4   program-order tag width; tags wrap modulo 2**TAG_W
// PORTS
// - clk_core      in   1          core clock
// - rst_core      in   1          reset: synchronous, active-high
// - flush_req     in   1          pipeline flush request
// - flush_ack     out  1          flush acknowledge
// - in_valid      in   N_SRC      per-source result valid
// - in_ready      out  N_SRC      per-source accept
// - in_tag        in   N_SRC*TAG_W  per-source program-order tag
// - in_rd         in   N_SRC*5    per-source destination register
// - in_result     in   N_SRC*32   per-source result word
// - in_exception  in   N_SRC      per-source exception flag
// - wb_en         out  1          register-file write enable
// - wb_rd         out  5          write address
// - wb_data       out  32         write data
// - trap_valid    out  1          one-cycle trap pulse
// - trap_tag      out  TAG_W      tag of the trapping instruction
// - commit_tag    out  TAG_W      next tag expected to retire
// BEHAVIOUR
// - Reset, applied at the clk_core edge while rst_core=1:
//   - state=RUN; commit_tag=0.
//   - wb_en=0, wb_rd=0, wb_data=0, trap_valid=0, trap_tag=0, flush_ack=0.
// - in_ready is combinational:
//   - in_ready[i]=1 only in RUN, with flush_req=0, in_valid[i]=1 and in_tag[i]==commit_tag.
//   - At most one in_ready bit is high per cycle. If several sources match, the lowest index wins.
//   - Duplicate tags are a protocol violation and must be flagged by a bench assertion.
// - Accept = in_valid[i] & in_ready[i]. Retired outputs are registered, with 1-cycle latency.
// - RUN, accept with no exception:
//   - wb_en <= (in_rd!=0); wb_rd/wb_data <= source fields.
//   - commit_tag <= commit_tag+1, wrapping from 2**TAG_W-1 to 0.
// - RUN, accept with exception:
//   - wb_en <= 0; trap_valid <= 1 for exactly one cycle; trap_tag <= commit_tag.
//   - commit_tag is not advanced; state <= TRAP.
// - TRAP: in_ready=0 on all sources; wb_en=0; wait for flush_req.
// - flush_req=1, in any state:
//   - all in_ready=0; the wb_en and trap_valid registers load 0; state <= FLUSH.
//   - flush_ack <= flush_req, so it follows flush_req with 1-cycle delay.
// - FLUSH: when flush_req=0, the next edge sets commit_tag <= 0 and state <= RUN.
// - Writeback hold rules:
//   - wb_en is a pulse and drops to 0 in any cycle with no accept.
//   - wb_rd/wb_data hold their last value.
// - rd==0 retires normally (tag advances) with wb_en=0.
// - Flush and accept in the same cycle cannot occur, because in_ready is gated by flush_req.
// - Reset mid-operation overrides everything, including flush and TRAP, and returns to reset values.
// TESTING
// - In-order retire:
//   - Stimulus: ALU presents tag0 (rd=5, 0x11) at the same time as src1 presents tag1 (rd=6, 0x22).
//   - Response: ALU retires in cycle 1 (wb 5<-0x11); src1 retires in cycle 2 (wb 6<-0x22);
//     commit_tag = 2.
// - Out-of-order arrival:
//   - Stimulus: src2 holds tag3 from cycle 0; tag2 arrives on the ALU at cycle 4.
//   - Response: src2 in_ready stays 0 until tag2 retires; tag3 retires on the following cycle.
// - Wrap-around (TAG_W=4):
//   - Stimulus: retire tags 14, 15, 0.
//   - Response: commit_tag goes 15 -> 0 -> 1; three wb pulses.
// - Exception:
//   - Stimulus: tag 7 with exception=1.
//   - Response: trap_valid=1 for one cycle with trap_tag=7; no wb; all in_ready=0 until flush.
// - Flush:
//   - Stimulus: assert flush_req for 3 cycles in TRAP.
//   - Response: flush_ack high for 3 cycles, lagging by 1; after deassert, commit_tag=0
//     and tag0 is accepted.
// - rd=0 and reset:
//   - Stimulus: tag0 with rd=0.
//   - Response: wb_en stays 0 and commit_tag = 1.
//   - Stimulus: pulse rst_core mid-stream.
//   - Response: all outputs return to 0 on the next edge.

Source files
------------

// File: rtl/hsv_core_commit.sv
// In-order commit stage: accepts per-unit results, retires them strictly by
// program-order tag, drives register-file writeback, and reports the first
// excepting instruction as a trap that holds until the core flushes.
module hsv_core_commit #(
    parameter int N_SRC = 3,
    parameter int TAG_W = 4
) (
    input  logic                   clk_core,
    input  logic                   rst_core,
    input  logic                   flush_req,
    output logic                   flush_ack,
    input  logic [N_SRC-1:0]       in_valid,
    output logic [N_SRC-1:0]       in_ready,
    input  logic [N_SRC*TAG_W-1:0] in_tag,
    input  logic [N_SRC*5-1:0]     in_rd,
    input  logic [N_SRC*32-1:0]    in_result,
    input  logic [N_SRC-1:0]       in_exception,
    output logic                   wb_en,
    output logic [4:0]             wb_rd,
    output logic [31:0]            wb_data,
    output logic                   trap_valid,
    output logic [TAG_W-1:0]       trap_tag,
    output logic [TAG_W-1:0]       commit_tag
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;

    logic [N_SRC-1:0] sel;
    logic             found;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;
    logic             sel_exc;

    // Pick the lowest-index source holding the next tag; nothing is accepted
    // outside RUN or while a flush is requested.
    always_comb begin
        sel      = '0;
        found    = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        sel_exc  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!found && state == RUN && !flush_req && in_valid[i] &&
                in_tag[i*TAG_W +: TAG_W] == commit_tag) begin
                found    = 1'b1;
                sel[i]   = 1'b1;
                sel_rd   = in_rd[i*5 +: 5];
                sel_data = in_result[i*32 +: 32];
                sel_exc  = in_exception[i];
            end
        end
    end

    assign in_ready = sel;

    // Commit FSM with registered writeback, trap and flush-acknowledge outputs.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            state      <= RUN;
            commit_tag <= '0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            trap_valid <= 1'b0;
            trap_tag   <= '0;
            flush_ack  <= 1'b0;
        end else begin
            flush_ack  <= flush_req;
            wb_en      <= 1'b0;
            trap_valid <= 1'b0;
            if (flush_req) begin
                state <= FLUSH;
            end else begin
                case (state)
                    RUN: begin
                        if (found) begin
                            if (sel_exc) begin
                                trap_valid <= 1'b1;
                                trap_tag   <= commit_tag;
                                state      <= TRAP;
                            end else begin
                                wb_en      <= (sel_rd != 5'd0);
                                wb_rd      <= sel_rd;
                                wb_data    <= sel_data;
                                commit_tag <= commit_tag + TAG_W'(1);
                            end
                        end
                    end
                    TRAP: begin
                        state <= TRAP;
                    end
                    FLUSH: begin
                        commit_tag <= '0;
                        state      <= RUN;
                    end
                    default: begin
                        state <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hsv_core_commit.sv
// Scoreboard bench for hsv_core_commit: directed stimulus pushes expected
// writeback/trap events; a negedge monitor pops and compares them.
module tb_hsv_core_commit;

    localparam int N_SRC = 3;
    localparam int TAG_W = 4;

    logic                   clk_core = 1'b0;
    logic                   rst_core;
    logic                   flush_req;
    logic                   flush_ack;
    logic [N_SRC-1:0]       in_valid;
    logic [N_SRC-1:0]       in_ready;
    logic [N_SRC*TAG_W-1:0] in_tag;
    logic [N_SRC*5-1:0]     in_rd;
    logic [N_SRC*32-1:0]    in_result;
    logic [N_SRC-1:0]       in_exception;
    logic                   wb_en;
    logic [4:0]             wb_rd;
    logic [31:0]            wb_data;
    logic                   trap_valid;
    logic [TAG_W-1:0]       trap_tag;
    logic [TAG_W-1:0]       commit_tag;

    typedef struct {
        bit         trap;
        logic [4:0] rd;
        logic [31:0] data;
        logic [3:0] tag;
    } ev_t;

    ev_t q[$];
    int  checks   = 0;
    int  failures = 0;

    hsv_core_commit #(.N_SRC(N_SRC), .TAG_W(TAG_W)) dut (
        .clk_core    (clk_core),
        .rst_core    (rst_core),
        .flush_req   (flush_req),
        .flush_ack   (flush_ack),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_tag      (in_tag),
        .in_rd       (in_rd),
        .in_result   (in_result),
        .in_exception(in_exception),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .trap_valid  (trap_valid),
        .trap_tag    (trap_tag),
        .commit_tag  (commit_tag)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic present(input int s, input logic [3:0] tag, input logic [4:0] rd,
                           input logic [31:0] data, input logic exc);
        in_valid[s]              = 1'b1;
        in_tag[s*TAG_W +: TAG_W] = tag;
        in_rd[s*5 +: 5]          = rd;
        in_result[s*32 +: 32]    = data;
        in_exception[s]          = exc;
    endtask

    task automatic clear(input int s);
        in_valid[s] = 1'b0;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
        ev_t e;
        e.trap = 1'b0; e.rd = rd; e.data = data; e.tag = '0;
        q.push_back(e);
    endtask

    task automatic push_trap(input logic [3:0] tag);
        ev_t e;
        e.trap = 1'b1; e.rd = '0; e.data = '0; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk_core);
        #1;
    endtask

    // Retire one non-excepting instruction on source s and check the tag advance.
    task automatic retire(input int s, input logic [3:0] tag, input logic [4:0] rd,
                          input logic [31:0] data);
        logic [3:0] nxt;
        logic [2:0] rdy;
        nxt = tag + 4'd1;
        rdy = 3'b001 << s;
        present(s, tag, rd, data, 1'b0);
        if (rd != 5'd0) push_wb(rd, data);
        @(negedge clk_core);
        check("retire_ready", {29'd0, in_ready}, {29'd0, rdy});
        next_cycle();
        clear(s);
        @(negedge clk_core);
        check("retire_commit_tag", {28'd0, commit_tag}, {28'd0, nxt});
        next_cycle();
    endtask

    // Monitor: every output pulse must match the oldest expected event.
    always @(negedge clk_core) begin
        if (wb_en || trap_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output wb_en=%b trap_valid=%b wb_rd=%0d wb_data=%h required=none",
                         wb_en, trap_valid, wb_rd, wb_data);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.trap) begin
                    check("trap_valid", {31'd0, trap_valid}, 32'd1);
                    check("trap_wb_en", {31'd0, wb_en}, 32'd0);
                    check("trap_tag", {28'd0, trap_tag}, {28'd0, e.tag});
                end else begin
                    check("wb_en", {31'd0, wb_en}, 32'd1);
                    check("wb_trap_valid", {31'd0, trap_valid}, 32'd0);
                    check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    check("wb_data", wb_data, e.data);
                end
            end
        end
    end

    // Two sources offering the same tag at once is a protocol violation.
    always @(negedge clk_core) begin
        for (int i = 0; i < N_SRC; i++) begin
            for (int j = i + 1; j < N_SRC; j++) begin
                assert (!(in_valid[i] && in_valid[j] &&
                          in_tag[i*TAG_W +: TAG_W] == in_tag[j*TAG_W +: TAG_W]))
                else $error("duplicate tag on sources %0d and %0d", i, j);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_core     = 1'b1;
        flush_req    = 1'b0;
        in_valid     = '0;
        in_tag       = '0;
        in_rd        = '0;
        in_result    = '0;
        in_exception = '0;
        next_cycle();
        next_cycle();
        rst_core = 1'b0;

        // Reset state
        @(negedge clk_core);
        check("rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_trap_valid", {31'd0, trap_valid}, 32'd0);
        check("rst_trap_tag", {28'd0, trap_tag}, 32'd0);
        check("rst_flush_ack", {31'd0, flush_ack}, 32'd0);
        check("rst_commit_tag", {28'd0, commit_tag}, 32'd0);
        next_cycle();

        // In-order retire: tag0 on ALU and tag1 on src1 together
        present(0, 4'd0, 5'd5, 32'h11, 1'b0);
        present(1, 4'd1, 5'd6, 32'h22, 1'b0);
        push_wb(5'd5, 32'h11);
        push_wb(5'd6, 32'h22);
        @(negedge clk_core);
        check("inorder_ready0", {29'd0, in_ready}, 32'b001);
        next_cycle();
        clear(0);
        @(negedge clk_core);
        check("inorder_ready1", {29'd0, in_ready}, 32'b010);
        next_cycle();
        clear(1);
        @(negedge clk_core);
        check("inorder_commit_tag", {28'd0, commit_tag}, 32'd2);
        next_cycle();

        // Out-of-order arrival: tag3 waits on src2 until tag2 retires
        present(2, 4'd3, 5'd7, 32'h33, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_core);
            check("ooo_wait_ready", {29'd0, in_ready}, 32'b000);
            next_cycle();
        end
        present(0, 4'd2, 5'd8, 32'h44, 1'b0);
        push_wb(5'd8, 32'h44);
        push_wb(5'd7, 32'h33);
        @(negedge clk_core);
        check("ooo_ready_alu", {29'd0, in_ready}, 32'b001);
        next_cycle();
        clear(0);
        @(negedge clk_core);
        check("ooo_ready_src2", {29'd0, in_ready}, 32'b100);
        next_cycle();
        clear(2);
        @(negedge clk_core);
        check("ooo_commit_tag", {28'd0, commit_tag}, 32'd4);
        next_cycle();

        // Wrap-around: retire tags 4..15 then 0
        for (int t = 4; t <= 16; t++) begin
            logic [3:0] tg;
            tg = 4'(t);
            retire(t % 3, tg, 5'd1, 32'h100 + 32'(t));
        end

        // Advance to tag 7
        for (int t = 1; t <= 6; t++) begin
            logic [3:0] tg;
            tg = 4'(t);
            retire(0, tg, 5'd2, 32'h200 + 32'(t));
        end

        // Exception on tag 7
        present(1, 4'd7, 5'd9, 32'hdead, 1'b1);
        push_trap(4'd7);
        @(negedge clk_core);
        check("exc_ready", {29'd0, in_ready}, 32'b010);
        next_cycle();
        clear(1);
        present(0, 4'd7, 5'd10, 32'hbeef, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_core);
            check("trap_hold_ready", {29'd0, in_ready}, 32'b000);
            check("trap_hold_commit_tag", {28'd0, commit_tag}, 32'd7);
            next_cycle();
        end
        clear(0);

        // Flush for three cycles while in TRAP
        flush_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_core);
            check("flush_ack", {31'd0, flush_ack}, (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            check("flush_ready", {29'd0, in_ready}, 32'b000);
            next_cycle();
            if (k == 2) flush_req = 1'b0;
        end
        check("flush_commit_tag", {28'd0, commit_tag}, 32'd0);

        // Tag0 with rd=0 retires without a writeback
        present(0, 4'd0, 5'd0, 32'h55, 1'b0);
        @(negedge clk_core);
        check("rd0_ready", {29'd0, in_ready}, 32'b001);
        next_cycle();
        clear(0);
        @(negedge clk_core);
        check("rd0_wb_en", {31'd0, wb_en}, 32'd0);
        check("rd0_commit_tag", {28'd0, commit_tag}, 32'd1);
        next_cycle();

        // Reset mid-stream
        retire(0, 4'd1, 5'd3, 32'h66);
        present(0, 4'd2, 5'd4, 32'h77, 1'b0);
        rst_core = 1'b1;
        next_cycle();
        rst_core = 1'b0;
        clear(0);
        @(negedge clk_core);
        check("mid_rst_wb_en", {31'd0, wb_en}, 32'd0);
        check("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        check("mid_rst_wb_data", wb_data, 32'd0);
        check("mid_rst_trap_valid", {31'd0, trap_valid}, 32'd0);
        check("mid_rst_trap_tag", {28'd0, trap_tag}, 32'd0);
        check("mid_rst_flush_ack", {31'd0, flush_ack}, 32'd0);
        check("mid_rst_commit_tag", {28'd0, commit_tag}, 32'd0);
        next_cycle();
        next_cycle();

        check("scoreboard_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
